// File: rtl/exp_horner_scale_pkg.sv
// exp_pkg: shared constants, widths and FSM encoding for the fixed-point exponential unit.
package exp_pkg;
    localparam int FRAC_W  = 12;
    localparam int SCALE_W = 20;
    localparam int ACC_W   = 15;
    localparam int P_W     = ACC_W + SCALE_W - FRAC_W;
    localparam logic [ACC_W-1:0] C_ONE   = 15'd4096;
    localparam logic [ACC_W-1:0] C_HALF  = 15'd2048;
    localparam logic [ACC_W-1:0] C_SIXTH = 15'd683;
    localparam logic [15:0]      Y_MAX   = 16'hFFFF;
    typedef enum logic [2:0] {IDLE, H1, H2, H3, MUL, OUT} exp_state_t;
endpackage

// File: rtl/exp_horner_scale_umul_shift.sv
// umul_shift: combinational unsigned multiply followed by a truncating right shift.
module umul_shift #(
    parameter int A_W = 15,
    parameter int B_W = 20,
    parameter int SH  = 12
) (
    input  logic [A_W-1:0]        a_i,
    input  logic [B_W-1:0]        b_i,
    output logic [A_W+B_W-SH-1:0] p_o
);
    logic [A_W+B_W-1:0] full;
    assign full = {{B_W{1'b0}}, a_i} * {{A_W{1'b0}}, b_i};
    assign p_o  = (A_W+B_W-SH)'(full >> SH);
endmodule

// File: rtl/exp_horner_scale.sv
// exp_horner_scale: e^x for signed Q4.12 x as scale_lookup(int part) * Horner(e^frac), saturated Q4.12 out.
module exp_horner_scale
    import exp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        x,
    output logic [3:0]         exp_int,
    input  logic [SCALE_W-1:0] exp_scale,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        y
);
    exp_state_t state_q, state_d;
    logic [15:0]        x_q, y_q, y_d;
    logic [ACC_W-1:0]   acc_q, acc_d, mul_a;
    logic [SCALE_W-1:0] mul_b;
    logic [P_W-1:0]     p;

    assign exp_int = x_q[15:12];
    assign y       = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = in_valid ? H1 : IDLE;
            H1:      state_d = H2;
            H2:      state_d = H3;
            H3:      state_d = MUL;
            MUL:     state_d = OUT;
            OUT:     state_d = out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    // One shared multiplier: f*coef during Horner steps, acc*scale in MUL.
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == OUT;
        mul_a     = state_q == H1 ? C_SIXTH : acc_q;
        mul_b     = state_q == MUL ? exp_scale : {{(SCALE_W-FRAC_W){1'b0}}, x_q[FRAC_W-1:0]};
    end

    umul_shift #(.A_W(ACC_W), .B_W(SCALE_W), .SH(FRAC_W)) u_mul (
        .a_i(mul_a),
        .b_i(mul_b),
        .p_o(p)
    );

    assign acc_d = (state_q == H1 ? C_HALF : C_ONE) + p[ACC_W-1:0];
    assign y_d   = |p[P_W-1:16] ? Y_MAX : p[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (state_q == IDLE && in_valid) x_q <= x;
            if (state_q inside {H1, H2, H3}) acc_q <= acc_d;
            if (state_q == MUL) y_q <= y_d;
        end
    end
endmodule

// File: tb/tb_exp_horner_scale.sv
// tb_exp_horner_scale: randomized and directed checks of exp_horner_scale against an arithmetic model.
module tb_exp_horner_scale;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [15:0] x = 0, y;
    logic [3:0]  exp_int;
    logic [19:0] exp_scale = 0;
    logic [19:0] scale_tbl [16];
    int          pass_cnt = 0, total = 0, cyc = 0;

    exp_horner_scale dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .exp_int(exp_int), .exp_scale(exp_scale), .out_valid(out_valid),
        .out_ready(out_ready), .y(y)
    );

    always #5 clk = ~clk;

    // Registered scale lookup stub.
    always @(posedge clk) begin
        exp_scale <= scale_tbl[exp_int];
        cyc <= cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [15:0] ref_y(input logic [15:0] xv, input logic [19:0] s);
        longint f, a, p;
        f = xv[11:0];
        a = 2048 + (f * 683) / 4096;
        a = 4096 + (f * a) / 4096;
        a = 4096 + (f * a) / 4096;
        p = (a * s) / 4096;
        return p > 65535 ? 16'hFFFF : 16'(p);
    endfunction

    task automatic run_op(input logic [15:0] xv, input logic [19:0] s, input bit hs,
                          output logic [15:0] yv, output int lat);
        scale_tbl[xv[15:12]] = s;
        @(negedge clk);
        x = xv;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        yv = y;
        if (hs) begin
            out_ready = 1;
            @(posedge clk);
            #1 out_ready = 0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (y !== 16'h0) $display("FAIL reset_y got %h want 0000", y); else pass_cnt++;
        total++; if (exp_int !== 4'h0) $display("FAIL reset_exp_int got %h want 0", exp_int); else pass_cnt++;
        rst_n = 1;
    endtask

    task automatic test_directed();
        logic [15:0] xs [4] = '{16'h0000, 16'h0800, 16'h1000, 16'h3FFF};
        logic [19:0] ss [4] = '{20'd4096, 20'd4096, 20'h02B80, 20'h07FF0};
        logic [15:0] ys [4] = '{16'h1000, 16'h1A55, 16'h2B80, 16'hFFFF};
        logic [15:0] yv;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ss[i], 1, yv, lat);
            total++; if (yv !== ys[i]) $display("FAIL directed_y[%0d] got %h want %h", i, yv, ys[i]); else pass_cnt++;
            total++; if (lat !== 5) $display("FAIL directed_latency[%0d] got %0d want 5", i, lat); else pass_cnt++;
            total++; if (exp_int !== xs[i][15:12]) $display("FAIL directed_exp_int[%0d] got %h want %h", i, exp_int, xs[i][15:12]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] xv, yv, ye;
        logic [19:0] s;
        int lat;
        for (int i = 0; i < 24; i++) begin
            xv = 16'($urandom);
            s  = (i % 2) ? 20'($urandom) : 20'($urandom_range(0, 8192));
            ye = ref_y(xv, s);
            run_op(xv, s, 1, yv, lat);
            total++; if (yv !== ye) $display("FAIL random_y x=%h s=%h got %h want %h", xv, s, yv, ye); else pass_cnt++;
            total++; if (exp_int !== xv[15:12]) $display("FAIL random_exp_int got %h want %h", exp_int, xv[15:12]); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] yv, ye;
        int lat, bad;
        ye = ref_y(16'h2400, 20'd9000);
        run_op(16'h2400, 20'd9000, 0, yv, lat);
        total++; if (yv !== ye) $display("FAIL stall_y got %h want %h", yv, ye); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin x = 16'h5123; in_valid = 1; end
            if (i == 6) in_valid = 0;
            if (y !== ye || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL stall_hold got %0d bad cycles want 0", bad); else pass_cnt++;
        total++; if (exp_int !== 4'h2) $display("FAIL stall_ignored_input exp_int got %h want 2", exp_int); else pass_cnt++;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready_before got %b want 0", in_ready); else pass_cnt++;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL stall_release_in_ready got %b want 1", in_ready); else pass_cnt++;
        total++; if (out_valid !== 1'b0) $display("FAIL stall_release_out_valid got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] xv, ye;
        logic [19:0] s;
        int prev, w;
        prev = 0;
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!in_ready && w < 20);
            if (k > 0) begin
                total++; if (cyc - prev !== 6) $display("FAIL b2b_spacing[%0d] got %0d want 6", k, cyc - prev); else pass_cnt++;
            end
            prev = cyc;
            xv = 16'($urandom);
            s  = 20'($urandom_range(0, 16384));
            scale_tbl[xv[15:12]] = s;
            ye = ref_y(xv, s);
            x = xv;
            in_valid = 1;
            @(posedge clk);
            #1 in_valid = 0;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!out_valid && w < 20);
            total++; if (y !== ye || out_valid !== 1'b1) $display("FAIL b2b_y[%0d] got %h valid %b want %h", k, y, out_valid, ye); else pass_cnt++;
        end
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] yv;
        int lat, pulses;
        scale_tbl[1] = 20'd12000;
        @(negedge clk);
        x = 16'h1800;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (y !== 16'h0) $display("FAIL rstmid_y got %h want 0000", y); else pass_cnt++;
        total++; if (exp_int !== 4'h0) $display("FAIL rstmid_exp_int got %h want 0", exp_int); else pass_cnt++;
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else pass_cnt++;
        pulses = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) pulses++;
        end
        total++; if (pulses !== 0) $display("FAIL rstmid_no_pulse got %0d valid cycles want 0", pulses); else pass_cnt++;
        run_op(16'h0000, 20'd4096, 1, yv, lat);
        total++; if (yv !== 16'h1000) $display("FAIL rstmid_next_y got %h want 1000", yv); else pass_cnt++;
        total++; if (lat !== 5) $display("FAIL rstmid_next_latency got %0d want 5", lat); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) scale_tbl[i] = 20'd4096;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
